gate_response_checker: RTL and testbench

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

---
 rtl/gate_chk_pkg.sv | 22 ++
 rtl/gate_chk_golden.sv | 19 +
 rtl/gate_response_checker.sv | 165 ++++++++++++++++
 tb/tb_gate_response_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
package gate_chk_pkg;

  localparam int unsigned VEC_W    = 2;
  localparam int unsigned NUM_RESP = 5;

  // Bit positions of each gate response within fail_mask / expected
  localparam int unsigned AND_B  = 0;
  localparam int unsigned OR_B   = 1;
  localparam int unsigned NOT_B  = 2;
  localparam int unsigned XOR_B  = 3;
  localparam int unsigned XNOR_B = 4;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/gate_chk_golden.sv
// Combinational expected responses of an ideal gate block for stimulus {a,b}.
module gate_chk_golden
  import gate_chk_pkg::*;
(
  input  logic                a,
  input  logic                b,
  output logic [NUM_RESP-1:0] expected
);

  always_comb begin
    expected         = '0;
    expected[AND_B]  = a & b;
    expected[OR_B]   = a | b;
    expected[NOT_B]  = ~a;
    expected[XOR_B]  = a ^ b;
    expected[XNOR_B] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps all four {a,b} vectors into a gate block and flags mismatching responses.
// Optional first-failure log enabled by defining GATE_CHK_FAIL_LOG_EN.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                a,
  output logic                b,
  input  logic                and_out,
  input  logic                or_out,
  input  logic                not_out,
  input  logic                xor_out,
  input  logic                xnor_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NUM_RESP-1:0] fail_mask
`ifdef GATE_CHK_FAIL_LOG_EN
  ,
  output logic                first_fail_valid,
  output logic [VEC_W-1:0]    first_fail_vec
`endif
);

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [VEC_W-1:0]    ab_q, ab_d;
  logic [7:0]          pass_cnt_q, pass_cnt_d;
  logic [3:0]          settle_q, settle_d;
  logic                pass_q, pass_d;
  logic [NUM_RESP-1:0] mask_q, mask_d;
  logic [NUM_RESP-1:0] expected, resp, mism;

  gate_chk_golden u_golden (
    .a        (ab_q[1]),
    .b        (ab_q[0]),
    .expected (expected)
  );

  always_comb begin
    resp         = '0;
    resp[AND_B]  = and_out;
    resp[OR_B]   = or_out;
    resp[NOT_B]  = not_out;
    resp[XOR_B]  = xor_out;
    resp[XNOR_B] = xnor_out;
    mism         = resp ^ expected;
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    ab_d       = ab_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    pass_d     = pass_q;
    mask_d     = mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d     = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          pass_cnt_d = '0;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        ab_d     = vec_q;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSample: begin
        mask_d  = mask_q | mism;
        vec_d   = vec_q + 1'b1;
        state_d = StDrive;
        if (vec_q == '1) begin
          pass_cnt_d = pass_cnt_q + 8'd1;
          if (pass_cnt_q == 8'(NUM_PASSES - 1)) begin
            // Verdict includes mismatches found in this final sample
            pass_d  = ((mask_q | mism) == '0);
            ab_d    = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      ab_q       <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      pass_q     <= 1'b0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      ab_q       <= ab_d;
      pass_cnt_q <= pass_cnt_d;
      settle_q   <= settle_d;
      pass_q     <= pass_d;
      mask_q     <= mask_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign fail_mask = mask_q;

`ifdef GATE_CHK_FAIL_LOG_EN
  logic             ff_valid_q, ff_valid_d;
  logic [VEC_W-1:0] ff_vec_q, ff_vec_d;

  always_comb begin
    ff_valid_d = ff_valid_q;
    ff_vec_d   = ff_vec_q;
    if (state_q == StIdle && start) begin
      ff_valid_d = 1'b0;
      ff_vec_d   = '0;
    end else if (state_q == StSample && (|mism) && !ff_valid_q) begin
      ff_valid_d = 1'b1;
      ff_vec_d   = ab_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
    end else begin
      ff_valid_q <= ff_valid_d;
      ff_vec_q   <= ff_vec_d;
    end
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: fault-injecting gate block, vector table and random faults.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2;
  logic [9:0] modes1, modes2;
  logic       a1, b1, a2, b2;
  logic [4:0] resp1, resp2;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [4:0] mask1, mask2;
`ifdef GATE_CHK_FAIL_LOG_EN
  logic       ffv1, ffv2;
  logic [1:0] ffvec1, ffvec2;
`endif

  int nchk  = 0;
  int nfail = 0;

  // Gate block under test; per output mode 0 ok, 1 stuck-0, 2 stuck-1, 3 inverted
  function automatic logic [4:0] gate_resp(input logic [9:0] modes, input logic a, input logic b);
    logic [4:0] ideal;
    logic [4:0] r;
    ideal = {~(a ^ b), a ^ b, ~a, a | b, a & b};
    r = '0;
    for (int i = 0; i < 5; i++) begin
      case (modes[2*i +: 2])
        2'd0: r[i] = ideal[i];
        2'd1: r[i] = 1'b0;
        2'd2: r[i] = 1'b1;
        default: r[i] = ~ideal[i];
      endcase
    end
    return r;
  endfunction

  always_comb resp1 = gate_resp(modes1, a1, b1);
  always_comb resp2 = gate_resp(modes2, a2, b2);

  gate_response_checker dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .and_out   (resp1[0]),
    .or_out    (resp1[1]),
    .not_out   (resp1[2]),
    .xor_out   (resp1[3]),
    .xnor_out  (resp1[4]),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .fail_mask (mask1)
`ifdef GATE_CHK_FAIL_LOG_EN
    ,
    .first_fail_valid (ffv1),
    .first_fail_vec   (ffvec1)
`endif
  );

  gate_response_checker #(
    .SETTLE_CYCLES (1),
    .NUM_PASSES    (2)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .a         (a2),
    .b         (b2),
    .and_out   (resp2[0]),
    .or_out    (resp2[1]),
    .not_out   (resp2[2]),
    .xor_out   (resp2[3]),
    .xnor_out  (resp2[4]),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .fail_mask (mask2)
`ifdef GATE_CHK_FAIL_LOG_EN
    ,
    .first_fail_valid (ffv2),
    .first_fail_vec   (ffvec2)
`endif
  );

  logic       sel;
  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [4:0] o_mask;
  always_comb begin
    o_a    = sel ? a2 : a1;
    o_b    = sel ? b2 : b1;
    o_busy = sel ? busy2 : busy1;
    o_done = sel ? done2 : done1;
    o_pass = sel ? pass2 : pass1;
    o_mask = sel ? mask2 : mask1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: enumerate the four vectors arithmetically and compare faulty vs ideal gates
  task automatic ref_model(input logic [9:0] modes, output logic [4:0] mask, output logic [1:0] first,
                           output bit firstv);
    int ideal [5];
    int act;
    mask = '0;
    first = '0;
    firstv = 0;
    for (int v = 0; v < 4; v++) begin
      int av = v / 2;
      int bv = v % 2;
      bit any = 0;
      ideal = '{av & bv, av | bv, 1 - av, av ^ bv, 1 - (av ^ bv)};
      for (int i = 0; i < 5; i++) begin
        case (int'(modes[2*i +: 2]))
          0: act = ideal[i];
          1: act = 0;
          2: act = 1;
          default: act = 1 - ideal[i];
        endcase
        if (act != ideal[i]) begin
          mask[i] = 1'b1;
          any = 1;
        end
      end
      if (any && !firstv) begin
        firstv = 1;
        first = 2'(v);
      end
    end
  endtask

  task automatic pulse_start(input logic s);
    if (s) start2 = 1'b1;
    else start1 = 1'b1;
  endtask

  task automatic run_check(input logic s, input int passes, input int exp_lat,
                           input logic [4:0] exp_mask, input bit exp_pass, input logic [1:0] exp_first,
                           input bit exp_firstv, input int repulse, input string name);
    int cyc;
    int nseq;
    int busy_after;
    logic [31:0] seq, exp_seq;
    logic [1:0] last_ab;
    bit have_last;
    sel = s;
    @(posedge clk); #1;
    pulse_start(s);
    cyc = 0; nseq = 0; seq = '0; last_ab = '0; have_last = 0;
    do begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start2 = 1'b0;
      cyc++;
      if (o_busy && (!have_last || {o_a, o_b} != last_ab)) begin
        seq = {seq[29:0], o_a, o_b};
        last_ab = {o_a, o_b};
        have_last = 1;
        nseq++;
      end
      if (repulse > 0 && cyc == repulse && o_busy) pulse_start(s);
    end while (!o_done && cyc < 2000);
    chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, " mask"}, 32'(o_mask), 32'(exp_mask));
    chk({name, " pass"}, 32'(o_pass), 32'(exp_pass));
    chk({name, " ab_busy_at_done"}, 32'({o_a, o_b, o_busy}), 32'd0);
    exp_seq = '0;
    for (int p = 0; p < passes; p++)
      for (int v = 0; v < 4; v++) exp_seq = {exp_seq[29:0], 2'(v)};
    chk({name, " ab_seq"}, seq, exp_seq);
    chk({name, " ab_seq_len"}, 32'(nseq), 32'(passes * 4));
`ifdef GATE_CHK_FAIL_LOG_EN
    chk({name, " first_fail"}, sel ? 32'({ffv2, ffvec2}) : 32'({ffv1, ffvec1}),
        32'({exp_firstv, exp_first}));
`else
    if (exp_firstv && exp_first == 2'd3 && exp_pass) $display("note: inconsistent table entry %s", name);
`endif
    // A start during the DONE cycle must be ignored
    if (repulse > 0) pulse_start(s);
    busy_after = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start2 = 1'b0;
      if (o_busy || o_done) busy_after++;
    end
    chk({name, " idle_after_done"}, 32'(busy_after), 32'd0);
    chk({name, " pass_hold"}, 32'(o_pass), 32'(exp_pass));
  endtask

  typedef struct {
    logic [9:0] modes;
    logic [4:0] mask;
    bit         pass;
    logic [1:0] first;
    bit         firstv;
  } vec_t;

  initial begin
    vec_t tbl [9];
    logic [4:0] m_mask;
    logic [1:0] m_first;
    bit m_firstv;
    int done_seen;
    logic r;

    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; modes1 = '0; modes2 = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy_done_pass", 32'({busy1, done1, pass1, busy2, done2, pass2}), 32'd0);
    chk("reset mask", 32'({mask1, mask2}), 32'd0);
    chk("reset ab", 32'({a1, b1, a2, b2}), 32'd0);
    rst_n = 1'b1;

    tbl[0] = '{10'h000, 5'b00000, 1, 2'd0, 0};
    tbl[1] = '{10'h040, 5'b01000, 0, 2'd1, 1};  // xor stuck 0
    tbl[2] = '{10'h030, 5'b00100, 0, 2'd0, 1};  // not inverted
    tbl[3] = '{10'h000, 5'b00000, 1, 2'd0, 0};  // clean rerun clears mask
    tbl[4] = '{10'h002, 5'b00001, 0, 2'd0, 1};  // and stuck 1
    tbl[5] = '{10'h004, 5'b00010, 0, 2'd1, 1};  // or stuck 0
    tbl[6] = '{10'h300, 5'b10000, 0, 2'd0, 1};  // xnor inverted
    tbl[7] = '{10'h001, 5'b00001, 0, 2'd3, 1};  // only the final vector fails
    tbl[8] = '{10'h020, 5'b00100, 0, 2'd2, 1};  // not stuck 1
    for (int i = 0; i < 9; i++) begin
      modes1 = tbl[i].modes;
      run_check(1'b0, 1, 17, tbl[i].mask, tbl[i].pass, tbl[i].first, tbl[i].firstv, 0,
                $sformatf("tbl%0d", i));
    end

    modes2 = '0;
    run_check(1'b1, 2, 25, 5'b00000, 1, 2'd0, 0, 10, "np2_clean");
    modes2 = 10'h040;
    run_check(1'b1, 2, 25, 5'b01000, 0, 2'd1, 1, 5, "np2_xor0");

    for (int i = 0; i < 16; i++) begin
      r = 1'(i % 2);
      if (r) modes2 = 10'($urandom);
      else modes1 = 10'($urandom);
      ref_model(r ? modes2 : modes1, m_mask, m_first, m_firstv);
      run_check(r, r ? 2 : 1, r ? 25 : 17, m_mask, m_mask == '0, m_first, m_firstv, r ? 7 : 0,
                $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a run aborts it without a done pulse
    sel = 1'b0;
    modes1 = 10'h002;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun mask_set", 32'(mask1), 32'd1);
    chk("midrun busy", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort outputs", 32'({a1, b1, busy1, done1, pass1, mask1}), 32'd0);
`ifdef GATE_CHK_FAIL_LOG_EN
    chk("abort first_fail", 32'({ffv1, ffvec1}), 32'd0);
`endif
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done1 || busy1) done_seen++;
    end
    chk("abort no_done", 32'(done_seen), 32'd0);
    modes1 = '0;
    run_check(1'b0, 1, 17, 5'b00000, 1, 2'd0, 0, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
